// File: rtl/axi_lite_master_ctrl.sv
// AXI4-Lite master: bridges the core's simple memory port onto AXI4-Lite.
// One request in flight; completion is held on ready until done.
module axi_lite_master_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              read,
  input  logic [1:0]        write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] store,
  input  logic              done,
  output logic              ready,
  output logic [DATA_W-1:0] load,
  output logic              err,
  output logic              awvalid,
  input  logic              awready,
  output logic [ADDR_W-1:0] awaddr,
  output logic [2:0]        awprot,
  output logic              wvalid,
  input  logic              wready,
  output logic [DATA_W-1:0] wdata,
  output logic [3:0]        wstrb,
  input  logic              bvalid,
  output logic              bready,
  input  logic [1:0]        bresp,
  output logic              arvalid,
  input  logic              arready,
  output logic [ADDR_W-1:0] araddr,
  output logic [2:0]        arprot,
  input  logic              rvalid,
  output logic              rready,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp
);

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    WRESP,
    RADDR,
    RDATA,
    COMPLETE
  } state_t;

  state_t state_q, state_d;

  logic              awvalid_d, wvalid_d;
  logic              bready_d, arvalid_d, rready_d;
  logic [ADDR_W-1:0] awaddr_d, araddr_d;
  logic [DATA_W-1:0] wdata_d, load_d;
  logic [3:0]        wstrb_d;
  logic              ready_d, err_d;

  logic [3:0] strb_base;
  logic [3:0] strb;
  logic       aw_left, w_left;

  assign awprot = 3'b000;
  assign arprot = 3'b000;

  always_comb begin
    strb_base = 4'b0000;
    case (write)
      2'b01:   strb_base = 4'b0001;
      2'b10:   strb_base = 4'b0011;
      2'b11:   strb_base = 4'b1111;
      default: strb_base = 4'b0000;
    endcase
  end

  // lanes shifted past lane 3 fall off the 4-bit result
  assign strb = strb_base << addr[1:0];

  assign aw_left = awvalid & ~awready;
  assign w_left  = wvalid & ~wready;

  always_comb begin
    state_d   = state_q;
    awvalid_d = awvalid;
    wvalid_d  = wvalid;
    bready_d  = bready;
    arvalid_d = arvalid;
    rready_d  = rready;
    awaddr_d  = awaddr;
    araddr_d  = araddr;
    wdata_d   = wdata;
    wstrb_d   = wstrb;
    load_d    = load;
    ready_d   = ready;
    err_d     = err;
    unique case (state_q)
      IDLE: begin
        if (write != 2'b00) begin
          awaddr_d  = addr;
          wdata_d   = store;
          wstrb_d   = strb;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          state_d   = WRITE;
        end else if (read) begin
          araddr_d  = addr;
          arvalid_d = 1'b1;
          state_d   = RADDR;
        end
      end
      WRITE: begin
        awvalid_d = aw_left;
        wvalid_d  = w_left;
        if (!aw_left && !w_left) begin
          bready_d = 1'b1;
          state_d  = WRESP;
        end
      end
      WRESP: begin
        if (bvalid) begin
          err_d    = (bresp != 2'b00);
          bready_d = 1'b0;
          ready_d  = 1'b1;
          state_d  = COMPLETE;
        end
      end
      RADDR: begin
        if (arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RDATA;
        end
      end
      RDATA: begin
        if (rvalid) begin
          load_d   = rdata;
          err_d    = (rresp != 2'b00);
          rready_d = 1'b0;
          ready_d  = 1'b1;
          state_d  = COMPLETE;
        end
      end
      COMPLETE: begin
        if (done) begin
          ready_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q <= IDLE;
      awvalid <= 1'b0;
      wvalid  <= 1'b0;
      bready  <= 1'b0;
      arvalid <= 1'b0;
      rready  <= 1'b0;
      awaddr  <= '0;
      araddr  <= '0;
      wdata   <= '0;
      wstrb   <= 4'b0000;
      load    <= '0;
      ready   <= 1'b0;
      err     <= 1'b0;
    end else begin
      state_q <= state_d;
      awvalid <= awvalid_d;
      wvalid  <= wvalid_d;
      bready  <= bready_d;
      arvalid <= arvalid_d;
      rready  <= rready_d;
      awaddr  <= awaddr_d;
      araddr  <= araddr_d;
      wdata   <= wdata_d;
      wstrb   <= wstrb_d;
      load    <= load_d;
      ready   <= ready_d;
      err     <= err_d;
    end
  end

endmodule

// File: tb/tb_axi_lite_master_ctrl.sv
// Directed bench for axi_lite_master_ctrl with a small AXI-Lite RAM slave.
// The slave reacts on the falling edge with configurable ready delays.
module tb_axi_lite_master_ctrl;

  logic        clk = 1'b0;
  logic        nrst;
  logic        read;
  logic [1:0]  write;
  logic [31:0] addr, store;
  logic        done;
  logic        ready, err;
  logic [31:0] load;
  logic        awvalid, wvalid, bready, arvalid, rready;
  logic [31:0] awaddr, araddr, wdata;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;
  logic        awready = 1'b0;
  logic        wready  = 1'b0;
  logic        bvalid  = 1'b0;
  logic        arready = 1'b0;
  logic        rvalid  = 1'b0;
  logic [1:0]  bresp   = 2'b00;
  logic [1:0]  rresp   = 2'b00;
  logic [31:0] rdata   = 32'd0;

  always #5 clk = ~clk;

  axi_lite_master_ctrl dut (
    .clk(clk), .nrst(nrst),
    .read(read), .write(write), .addr(addr), .store(store),
    .done(done), .ready(ready), .load(load), .err(err),
    .awvalid(awvalid), .awready(awready),
    .awaddr(awaddr), .awprot(awprot),
    .wvalid(wvalid), .wready(wready),
    .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready),
    .araddr(araddr), .arprot(arprot),
    .rvalid(rvalid), .rready(rready),
    .rdata(rdata), .rresp(rresp)
  );

  int n_chk = 0;
  int n_err = 0;

  int         aw_dly = 0;
  int         w_dly  = 0;
  logic [1:0] bresp_cfg = 2'b00;

  logic [31:0] mem [16] = '{default: 32'd0};
  int          aw_cnt = 0, w_cnt = 0;
  int          aw_beats = 0, w_beats = 0, ar_beats = 0;
  int          viol = 0;
  logic        aw_got = 0, w_got = 0, ar_got = 0;
  logic        b_hs = 0, r_hs = 0;
  logic [31:0] aw_addr_s = 0, w_data_s = 0, ar_addr_s = 0;
  logic [3:0]  w_strb_s = 0;

  // handshakes flagged here complete on the following rising edge
  always @(negedge clk) begin
    if (bready && (awvalid || wvalid)) viol++;
    if (b_hs) begin bvalid = 0; b_hs = 0; end
    if (aw_got && w_got && !bvalid) begin
      for (int i = 0; i < 4; i++)
        if (w_strb_s[i])
          mem[aw_addr_s[5:2]][i*8 +: 8] = w_data_s[i*8 +: 8];
      bvalid = 1; bresp = bresp_cfg;
      aw_got = 0; w_got = 0;
    end
    if (bvalid && bready) b_hs = 1;
    if (r_hs) begin rvalid = 0; r_hs = 0; end
    if (ar_got && !rvalid) begin
      rvalid = 1; rdata = mem[ar_addr_s[5:2]]; rresp = 2'b00;
      ar_got = 0;
    end
    if (rvalid && rready) r_hs = 1;
    if (awvalid) begin
      if (aw_cnt >= aw_dly) awready = 1;
      else begin awready = 0; aw_cnt++; end
    end else begin awready = 0; aw_cnt = 0; end
    if (awvalid && awready) begin
      aw_got = 1; aw_addr_s = awaddr; aw_beats++;
    end
    if (wvalid) begin
      if (w_cnt >= w_dly) wready = 1;
      else begin wready = 0; w_cnt++; end
    end else begin wready = 0; w_cnt = 0; end
    if (wvalid && wready) begin
      w_got = 1; w_data_s = wdata; w_strb_s = wstrb; w_beats++;
    end
    arready = arvalid;
    if (arvalid && arready) begin
      ar_got = 1; ar_addr_s = araddr; ar_beats++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic req(input logic rd, input logic [1:0] wr,
                     input logic [31:0] a, input logic [31:0] s,
                     output int lat);
    @(posedge clk); #1;
    lat = 0;
    read = rd; write = wr; addr = a; store = s;
    while (ready !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("ready_seen", {31'd0, ready}, 32'd1);
    done = 1;
    @(posedge clk); #1;
    done = 0; read = 0; write = 0;
    chk("ready_clr", {31'd0, ready}, 32'd0);
  endtask

  int lat;
  int awb0, wb0, arb0;

  initial begin
    nrst = 0; read = 0; write = 0; addr = 0; store = 0; done = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_awvalid", {31'd0, awvalid}, 0);
    chk("rst_wvalid", {31'd0, wvalid}, 0);
    chk("rst_bready", {31'd0, bready}, 0);
    chk("rst_arvalid", {31'd0, arvalid}, 0);
    chk("rst_rready", {31'd0, rready}, 0);
    chk("rst_ready", {31'd0, ready}, 0);
    chk("rst_load", load, 0);
    chk("rst_err", {31'd0, err}, 0);
    nrst = 1;

    req(0, 2'b10, 32'h22, 32'h5678_0000, lat);
    chk("hw_lat", lat, 3);
    chk("hw_awaddr", aw_addr_s, 32'h22);
    chk("hw_wstrb", {28'd0, w_strb_s}, 32'hC);
    chk("hw_wdata", w_data_s, 32'h5678_0000);
    chk("hw_err", {31'd0, err}, 0);
    chk("hw_load", load, 0);

    req(0, 2'b10, 32'h20, 32'hABCD_1234, lat);
    chk("hw2_wstrb", {28'd0, w_strb_s}, 32'h3);
    req(1, 2'b00, 32'h20, 32'h0, lat);
    chk("rd_lat", lat, 3);
    chk("rd_araddr", ar_addr_s, 32'h20);
    chk("rd_load", load, 32'h5678_1234);
    chk("rd_err", {31'd0, err}, 0);

    awb0 = aw_beats; wb0 = w_beats;
    aw_dly = 3; w_dly = 0;
    req(0, 2'b11, 32'h10, 32'hDEAD_BEEF, lat);
    chk("awslow_lat", lat, 6);
    chk("awslow_wstrb", {28'd0, w_strb_s}, 32'hF);
    aw_dly = 0; w_dly = 3;
    req(0, 2'b11, 32'h14, 32'hCAFE_F00D, lat);
    chk("wslow_lat", lat, 6);
    chk("slow_aw_beats", aw_beats - awb0, 2);
    chk("slow_w_beats", w_beats - wb0, 2);
    chk("slow_bready_early", viol, 0);
    w_dly = 0;

    bresp_cfg = 2'b10;
    req(0, 2'b11, 32'h18, 32'h1234_5678, lat);
    chk("slverr_err", {31'd0, err}, 1);
    chk("wr_keeps_load", load, 32'h5678_1234);
    bresp_cfg = 2'b00;
    req(1, 2'b00, 32'h14, 32'h0, lat);
    chk("ok_rd_err", {31'd0, err}, 0);
    chk("ok_rd_load", load, 32'hCAFE_F00D);

    arb0 = ar_beats; awb0 = aw_beats;
    req(1, 2'b01, 32'h03, 32'h1100_0000, lat);
    chk("prio_wstrb", {28'd0, w_strb_s}, 32'h8);
    chk("prio_awaddr", aw_addr_s, 32'h03);
    chk("prio_no_ar", ar_beats - arb0, 0);
    chk("prio_aw", aw_beats - awb0, 1);

    req(0, 2'b10, 32'h23, 32'h7700_0000, lat);
    chk("hw_edge_wstrb", {28'd0, w_strb_s}, 32'h8);
    req(1, 2'b00, 32'h20, 32'h0, lat);
    chk("mem_merge", load, 32'h7778_1234);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/axi_lite_master_ctrl.md
Name: axi_lite_master_ctrl

Overview:
- AXI4-Lite master bridging the core's simple memory request port (read/write/addr/store → ready/load) onto an AXI4-Lite bus.
- Accepts one request at a time, runs the AXI address/data/response phases, and presents completion with `ready`.
- Holds `ready` until the requester acknowledges with `done`.
- Sits between the CPU memory stage and AXI slave controllers (ROM, RAM, peripherals).

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width (fixed at 32; strobe logic assumes 4 byte lanes)

Ports:
- clk  in  1  clock; all logic on rising edge
- nrst  in  1  synchronous active-low reset
- read  in  1  read request, held until done
- write  in  2  write size: 00 none, 01 byte, 10 halfword, 11 word; held until done
- addr  in  32  byte address
- store  in  32  write data, already lane-aligned to addr[1:0]
- done  in  1  requester acknowledge of ready
- ready  out  1  transaction complete
- load  out  32  read data, full 32-bit word
- err  out  1  last response was not OKAY
- awvalid, awready, awaddr[31:0], awprot[2:0]  out/in/out/out  write-address channel
- wvalid, wready, wdata[31:0], wstrb[3:0]  out/in/out/out  write-data channel
- bvalid, bready, bresp[1:0]  in/out/in  write-response channel
- arvalid, arready, araddr[31:0], arprot[2:0]  out/in/out/out  read-address channel
- rvalid, rready, rdata[31:0], rresp[1:0]  in/out/in/in  read-data channel

Behaviour:
- Reset (nrst low at clk edge): state IDLE; all valid/ready outputs 0; ready=0, err=0, load=0, addresses/data/strobes 0. Reset mid-transaction abandons it immediately.
- States: IDLE, WRITE (AW and W outstanding), WRESP, RADDR, RDATA, COMPLETE.
- IDLE:
  - write!=00 → latch addr/store/strobe; go WRITE with awvalid=wvalid=1.
  - else read=1 → latch addr; go RADDR with arvalid=1.
  - Write has priority when both are set.
- Strobe: base mask 0001 (byte), 0011 (halfword), 1111 (word), shifted left by addr[1:0]; bits beyond lane 3 are dropped.
- wdata = store unmodified; awaddr/araddr = addr unmodified; awprot/arprot = 000.
- WRITE: awvalid drops after its awready handshake and wvalid after its wready handshake, independently. When both channels have completed (same or different cycles), go WRESP with bready=1.
- WRESP: on bvalid, latch err = (bresp!=00), drop bready, go COMPLETE.
- RADDR: on arready, drop arvalid, raise rready, go RDATA.
- RDATA: on rvalid, latch load=rdata and err=(rresp!=00), drop rready, go COMPLETE.
- COMPLETE: ready=1; stays until done=1 sampled, then ready=0 and IDLE. Requester must drop read/write in the cycle after done.
- load holds its value until the next read completes. Writes do not alter load.
- Valid signals never drop before their handshake.
- Latency with a zero-wait slave:
  - Write: valids in the cycle after request; ready 3 cycles after request.
  - Read: ready 3 cycles after request.
- All outputs are registered.

Test Plan:
- Reset: hold nrst low 2 cycles → all AXI valids/readies 0, ready=0, load=0.
- Halfword write, size 10, addr 0x22, store 0x56780000 → awaddr=0x22, wstrb=1100, wdata=0x56780000; ready after bvalid; cleared one cycle after done.
- Halfword write at 0x20 with 0xABCD1234 (wstrb=0011), then word read at 0x20 from RAM/ROM controller → load=0x56781234, err=0.
- Slave inserts awready 3 cycles after wready (and vice versa) → bready asserted only after both handshakes; no duplicate AW/W beats.
- Slave returns bresp=10 → err=1 with ready. Next OKAY read clears err.
- read and write both asserted in IDLE → write performed first, no AR issued; byte write at addr 0x03 gives wstrb=1000.
